demux12_buf: RTL and testbench
==============================

# demux12_buf

Buffered 1-to-2 demultiplexer. It routes a valid/ready input stream to one of two output streams, chosen per word by a select bit, so it is the reverse of the 2:1 mux used in the lab datapath. Each output has its own first-word-fall-through FIFO, so a stalled consumer on one side does not block words routed to the other side until that side's FIFO fills. It sits between a single producer and two independent consumers.

## Interface
Parameters:
- `WIDTH`, default 8: data width in bits.
- `DEPTH`, default 2: entries per output FIFO. Must be a power of 2 and at least 2.

Ports:
- `Clk`  in  1  single clock. All state changes on its rising edge.
- `Reset_L`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination: 0 routes to out0, 1 routes to out1. Qualified by `in_valid`.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  the selected FIFO can accept the word.
- `out0_data`, `out1_data`  out  WIDTH  head word of each FIFO.
- `out0_valid`, `out1_valid`  out  1  that FIFO is non-empty.
- `out0_ready`, `out1_ready`  in  1  that consumer takes the head word.
- `cnt0`, `cnt1`  out  8  number of words accepted into each channel, modulo 256.

## Operation
- Per-FIFO state: write pointer, read pointer, occupancy count (0..DEPTH, log2(DEPTH)+1 bits), and storage array.
- `in_ready` = `in_sel` ? !full1 : !full0. It is combinational and depends only on `in_sel` and the FIFO state.
- Push to channel N: `in_valid & in_ready & (in_sel==N)`. The word is written at the write pointer, the pointer increments with wrap, and `cntN` increments with wrap from 255 to 0.
- Pop from channel N: `outN_valid & outN_ready`. The read pointer increments with wrap.
- Occupancy update per channel: push only gives +1, pop only gives −1, push and pop together leave it unchanged.
- Full FIFO: `in_ready` is 0 for that select, even if the same FIFO pops in the same cycle. There is no pass-through of a word directly to the output.
- Empty FIFO: `outN_valid` is 0, and `outN_ready` has no effect.
- `outN_data` = storage[read pointer]. It holds its value while `outN_valid & !outN_ready`.
- Both channels may pop in the same cycle. Only one channel can be pushed per cycle.
- If `in_valid` is 0, `in_sel` and `in_data` are ignored.

## Timing
- Latency: a word accepted at rising edge k is visible on `outN_data` with `outN_valid`=1 after edge k, i.e. 1 cycle.
- Throughput: one word per cycle into the design. Each output sustains one word per cycle while it is non-empty.
- Reset (`Reset_L`=0, asynchronous) clears:
  - all pointers and counts to 0
  - storage to 0
  - `cnt0`/`cnt1` to 0
  - `out0_valid`/`out1_valid` to 0
  - `out0_data`/`out1_data` to 0
- While in reset, `in_ready`=1 (both FIFOs are empty), but no pushes take effect.
- Reset asserted mid-stream discards all buffered words immediately. The first edge after deassertion behaves as from empty.
- Order within a channel is FIFO. There is no ordering relationship between the two channels.

## Structure
- Shared package `demux_pkg`:
  - `DEMUX_WIDTH` default (8)
  - `DEMUX_DEPTH` default (2)
  - channel constants `CH0`=0 and `CH1`=1
- Sub-module `fifo_fwft` (parameters WIDTH, DEPTH; ports Clk, Reset_L, push, wdata, full, pop, rdata, empty). It is instantiated twice.
- The top level contains only push decode, `in_ready` selection, and the two 8-bit accept counters.

## Test plan
- After reset, drive `in_valid`=1, `in_sel`=0, `in_data`=8'hA5 for 1 cycle. Expected: next cycle `out0_valid`=1, `out0_data`=8'hA5, `out1_valid`=0, `cnt0`=1.
- With `out1_ready`=0, push 8'h11, 8'h22 with `in_sel`=1. Expected: third attempt sees `in_ready`=0. A push with `in_sel`=0 of 8'h33 is still accepted. Raising `out1_ready` drains 8'h11 then 8'h22 in order.
- FIFO0 full with simultaneous pop and push attempt. Expected: `in_ready`=0 that cycle, and the count drops to 1.
- FIFO0 holding 1 word, with push and pop on the same edge. Expected: the count stays 1, and `out0_data` becomes the new word.
- Push 256 words to channel 0 with `out0_ready`=1. Expected: `cnt0` wraps to 0, and all words emerge in order with 1-cycle latency.
- Push 2 words to each channel, then pulse `Reset_L` low asynchronously mid-cycle. Expected: `out0_valid`/`out1_valid`/`cnt0`/`cnt1`/`out0_data`/`out1_data` are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults and channel constants for the buffered 1:2 demux.
package demux_pkg;
  localparam int DEMUX_WIDTH = 8;
  localparam int DEMUX_DEPTH = 2;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
endpackage

// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO. Ports: Clk, Reset_L (async, active-low),
// push/wdata/full on the write side, pop/rdata/empty on the read side.
module fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic doPush, doPop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // Full blocks writes even when a pop happens the same cycle; there is no bypass.
  assign doPush = push & !full;
  assign doPop = pop & !empty;
  assign rdata = mem[rdPtr];
  always_ff @(posedge Clk or negedge Reset_L)
    if (!Reset_L) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wdata;
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
endmodule

// File: rtl/demux12_buf.sv
// demux12_buf: buffered 1:2 demux. Ports: Clk, Reset_L (async, active-low), in_* producer
// stream with in_sel destination, out0_*/out1_* consumer streams, cnt0/cnt1 accept counters.
import demux_pkg::*;

module demux12_buf #(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);
  logic full0, full1, empty0, empty1, push0, push1;
  assign in_ready = in_sel ? !full1 : !full0;
  assign push0 = in_valid & in_ready & (in_sel == CH0);
  assign push1 = in_valid & in_ready & (in_sel == CH1);
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo0 (
    .Clk(Clk), .Reset_L(Reset_L), .push(push0), .wdata(in_data), .full(full0),
    .pop(out0_ready), .rdata(out0_data), .empty(empty0)
  );
  fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo1 (
    .Clk(Clk), .Reset_L(Reset_L), .push(push1), .wdata(in_data), .full(full1),
    .pop(out1_ready), .rdata(out1_data), .empty(empty1)
  );
  always_ff @(posedge Clk or negedge Reset_L)
    if (!Reset_L) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + 8'd1;
      if (push1) cnt1 <= cnt1 + 8'd1;
    end
endmodule

// File: tb/tb_demux12_buf.sv
// tb_demux12_buf: table-driven and scoreboard checks of demux12_buf with DEPTH=2.
module tb_demux12_buf;
  localparam int DEPTH = 2;
  logic Clk = 1'b0;
  logic Reset_L;
  logic [7:0] in_data;
  logic in_sel, in_valid, in_ready;
  logic [7:0] out0_data, out1_data;
  logic out0_valid, out1_valid, out0_ready, out1_ready;
  logic [7:0] cnt0, cnt1;
  int errors = 0;
  int checks = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] c0m, c1m;

  typedef struct {
    logic v;
    logic sel;
    logic [7:0] d;
    logic r0;
    logic r1;
    logic rdy;
  } vec_t;
  vec_t tbl[16];

  demux12_buf #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out0_data(out0_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out1_data(out1_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One cycle, starting and ending at a falling edge. The expected in_ready comes from
  // the caller; the queues model FIFO contents and the expected counters.
  task automatic cycle(input logic v, input logic sel, input logic [7:0] d,
                       input logic r0, input logic r1, input logic expRdy);
    logic pop0, pop1;
    in_valid = v;
    in_sel = sel;
    in_data = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    chk("in_ready", in_ready, expRdy);
    chk("out0_valid", out0_valid, q0.size() != 0);
    chk("out1_valid", out1_valid, q1.size() != 0);
    if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    pop0 = r0 && q0.size() != 0;
    pop1 = r1 && q1.size() != 0;
    @(posedge Clk);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (v && expRdy) begin
      if (sel) begin q1.push_back(d); c1m++; end
      else begin q0.push_back(d); c0m++; end
    end
    @(negedge Clk);
    chk("cnt0", cnt0, c0m);
    chk("cnt1", cnt1, c1m);
  endtask

  task automatic checkCleared(input string tag);
    chk({tag, " out0_valid"}, out0_valid, 0);
    chk({tag, " out1_valid"}, out1_valid, 0);
    chk({tag, " out0_data"}, out0_data, 0);
    chk({tag, " out1_data"}, out1_data, 0);
    chk({tag, " cnt0"}, cnt0, 0);
    chk({tag, " cnt1"}, cnt1, 0);
    chk({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic doReset();
    Reset_L = 1'b0;
    in_valid = 1'b0;
    q0.delete();
    q1.delete();
    c0m = 8'd0;
    c1m = 8'd0;
    repeat (2) @(negedge Clk);
    checkCleared("reset");
    Reset_L = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    in_data = 8'h00;
    in_sel = 1'b0;
    in_valid = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    @(negedge Clk);
    doReset();
    foreach (tbl[i]) cycle(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1, tbl[i].rdy);
    chk("table drained0", q0.size(), 0);
    chk("table drained1", q1.size(), 0);
    // 256 back-to-back words into channel 0 with the consumer always ready
    doReset();
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, 8'(i) ^ 8'h5A, 1'b1, 1'b0, 1'b1);
    chk("cnt0 wrap", cnt0, 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("wrap drained", out0_valid, 0);
    // fill both channels, then reset asynchronously between clock edges
    cycle(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'hD2, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    Reset_L = 1'b0;
    #1;
    checkCleared("async");
    q0.delete();
    q1.delete();
    c0m = 8'd0;
    c1m = 8'd0;
    @(negedge Clk);
    Reset_L = 1'b1;
    cycle(1'b1, 1'b1, 8'h9C, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
